mc_controller: RTL
==================

Name: mc_controller

Overview:
- Multicycle successor to the single-cycle processor controller; sequences each ARM-subset instruction over 3–5+ cycles through a main FSM.
- Shares one memory port and one ALU per instruction.
- Holds the NZCV flag register and the per-instruction condition-execute bit.
- Adds parametrised ALU-control width and an optional multi-cycle MUL path.

Parameters:
- ALUCTRL_W, 3, width of ALUControl (minimum 3).
- ENABLE_MUL, 1, 1 = decode MUL (Op=00, I=0, cmd=0000, Instr[7:4]=1001) into EXECMUL state.
- MUL_LAT, 2, cycles spent in EXECMUL (range 1–15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- Instr  in  32  instruction register contents.
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle.
- PCWrite  out  1  PC load enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUResult reg.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register load.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  1  0 = RD1, 1 = PC.
- ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4.
- RegSrc  out  2  register read address selects.
- ImmSrc  out  2  immediate extend select.
- ALUControl  out  ALUCTRL_W  ALU operation select.
- State  out  4  current FSM state, for debug.
- Illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Reset (asynchronous):
  - state = FETCH, flags = 0000, cond_ex_q = 0, mul_cnt = 0.
  - While reset is high, PCWrite, IRWrite, MemWrite, RegWrite and Illegal are forced to 0.
  - Reset asserted mid-instruction aborts it; no write completes.
- Combinational decode from Instr in every state:
  - ImmSrc = Instr[27:26].
  - RegSrc[0] = (Op==10).
  - RegSrc[1] = (Op==01).
- ALU op encoding from cmd = Instr[24:21]:
  - 0100 ADD = 0.
  - 0010 SUB = 1.
  - 0000 AND = 2.
  - 1100 ORR = 3.
  - 0001 EOR = 4.
  - 1010 CMP = SUB with NoWrite = 1 (S required).
  - MUL = 5.
  - Unlisted cmd = ADD with NoWrite = 1.
  - Upper bits of ALUControl are zero-extended.
- Condition evaluation on Instr[31:28] against the stored flags:
  - EQ/NE: Z.
  - CS/CC: C.
  - MI/PL: N.
  - VS/VC: V.
  - HI: C & ~Z; LS: its complement.
  - GE: N==V; LT: its complement.
  - GT: ~Z & (N==V); LE: its complement.
  - AL (1110) = 1; 1111 = 0.
  - Result is latched into cond_ex_q on the clock edge leaving DECODE.
- FSM states, outputs and transitions (unlisted outputs are 0):
  - FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10 → DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. Next state by Op:
    - 01 → MEMADR.
    - 10 → BRANCH.
    - 00 and MUL pattern with ENABLE_MUL → EXECMUL.
    - 00 and I=1 → EXECUTEI.
    - 00 otherwise → EXECUTER.
    - 11 → FETCH with Illegal=1.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD if Instr[23] else SUB. Next: Instr[20] ? MEMRD : MEMWR.
  - MEMRD: AdrSrc=1 → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=cond_ex_q → FETCH.
  - MEMWR: AdrSrc=1, MemWrite=cond_ex_q → FETCH.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, decoded op → ALUWB.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, decoded op → ALUWB.
  - EXECMUL: ALUSrcB=00, op MUL. mul_cnt increments each cycle; leaves for ALUWB when mul_cnt == MUL_LAT-1, then mul_cnt clears.
  - ALUWB: ResultSrc=00, RegWrite = cond_ex_q & ~NoWrite. If Instr[15:12]==15 and a write is occurring, PCWrite is also 1 (branch via Rd=PC). → FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=cond_ex_q → FETCH.
- Flag update, on the clock edge leaving the last execute cycle (EXECUTER, EXECUTEI, or final EXECMUL), only when S = Instr[20] = 1 and cond_ex_q = 1:
  - N and Z always update.
  - C and V update only for ADD/SUB/CMP.
  - MUL updates N and Z only.
- Instruction latency:
  - Data processing: 4 cycles.
  - MUL: 3 + MUL_LAT cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Branch: 3 cycles.
  - Failing-condition instructions take the same cycle count with all writes suppressed.
- State encoding:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, EXECMUL 10.
  - Any other state value → FETCH.

Test Plan:
- Reset released, Instr=E0812003 (ADD R2,R1,R3):
  - States 0→1→6→8→0.
  - RegWrite=1 only in ALUWB.
  - ALUControl=0 in EXECUTER.
- Flags Z=1, Instr=0A000002 (BEQ): BRANCH has PCWrite=1. Same instruction with Z=0: PCWrite=0 in BRANCH; next state is FETCH.
- Instr=E5912004 (LDR): states 0,1,2,3,4, AdrSrc=1 in MEMRD, ResultSrc=01 with RegWrite=1 in MEMWB. Instr=E5812004 (STR): MemWrite=1 exactly one cycle.
- CMP flag update:
  - Instr=E1510002 (CMP) with ALUFlags=0100 → stored flags become 0100; RegWrite=0.
  - Then Instr=E0110002 (ANDS) with ALUFlags=1011 → flags become 1000 (C and V retained from prior 0,0).
- ENABLE_MUL=1, MUL_LAT=3, Instr=E0020391 (MUL): exactly 3 cycles in state 10 with ALUControl=5, then ALUWB.
- Edge cases:
  - Assert reset during MEMWR: MemWrite drops immediately and state=0 asynchronously.
  - Instr=EC000000 (Op=11): Illegal pulses 1 cycle in DECODE, returns to FETCH.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle ARM-subset controller: main sequencing FSM, instruction decode,
// NZCV flag register and per-instruction condition-execute bit.
module mc_controller #(
  parameter int unsigned ALUCTRL_W  = 3,
  parameter bit          ENABLE_MUL = 1'b1,
  parameter int unsigned MUL_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           RegSrc,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           State,
  output logic                 Illegal
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 4;

  localparam logic [OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [OP_W-1:0] ALU_AND = 3'd2;
  localparam logic [OP_W-1:0] ALU_ORR = 3'd3;
  localparam logic [OP_W-1:0] ALU_EOR = 3'd4;
  localparam logic [OP_W-1:0] ALU_MUL = 3'd5;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    EXECMUL  = 4'd10
  } state_t;

  state_t           state, state_nx;
  logic [3:0]       flags;
  logic             cond_ex_q;
  logic [CNT_W-1:0] mul_cnt;

  logic [1:0]       op;
  logic [3:0]       cmd;
  logic             s_bit;
  logic             is_mul;
  logic             mul_done;
  logic [OP_W-1:0]  dp_op;
  logic             nowrite;
  logic             cv_upd;
  logic             cond_ok;
  logic             exec_last;
  logic             unused_instr;

  assign op       = Instr[27:26];
  assign cmd      = Instr[24:21];
  assign s_bit    = Instr[20];
  assign is_mul   = ENABLE_MUL && (op == 2'b00) && !Instr[25] && (cmd == 4'b0000)
                    && (Instr[7:4] == 4'b1001);
  assign mul_done = (mul_cnt == CNT_W'(MUL_LAT - 1));
  assign unused_instr = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

  assign ImmSrc = Instr[27:26];
  assign RegSrc = {op == 2'b01, op == 2'b10};
  assign State  = state;

  // Data-processing op decode; unlisted cmds become a non-writing ADD
  always_comb begin
    dp_op   = ALU_ADD;
    nowrite = 1'b0;
    cv_upd  = 1'b0;
    if (is_mul) begin
      dp_op = ALU_MUL;
    end else begin
      case (cmd)
        4'b0100: begin dp_op = ALU_ADD; cv_upd = 1'b1; end
        4'b0010: begin dp_op = ALU_SUB; cv_upd = 1'b1; end
        4'b0000: dp_op = ALU_AND;
        4'b1100: dp_op = ALU_ORR;
        4'b0001: dp_op = ALU_EOR;
        4'b1010: begin dp_op = ALU_SUB; nowrite = 1'b1; cv_upd = 1'b1; end
        default: nowrite = 1'b1;
      endcase
    end
  end

  // Condition check against stored {N,Z,C,V}
  always_comb begin
    cond_ok = 1'b0;
    case (Instr[31:28])
      4'h0: cond_ok = flags[2];
      4'h1: cond_ok = ~flags[2];
      4'h2: cond_ok = flags[1];
      4'h3: cond_ok = ~flags[1];
      4'h4: cond_ok = flags[3];
      4'h5: cond_ok = ~flags[3];
      4'h6: cond_ok = flags[0];
      4'h7: cond_ok = ~flags[0];
      4'h8: cond_ok = flags[1] & ~flags[2];
      4'h9: cond_ok = ~(flags[1] & ~flags[2]);
      4'hA: cond_ok = (flags[3] == flags[0]);
      4'hB: cond_ok = (flags[3] != flags[0]);
      4'hC: cond_ok = ~flags[2] & (flags[3] == flags[0]);
      4'hD: cond_ok = ~(~flags[2] & (flags[3] == flags[0]));
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign exec_last = (state == EXECUTER) || (state == EXECUTEI)
                     || ((state == EXECMUL) && mul_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      flags     <= 4'b0000;
      cond_ex_q <= 1'b0;
      mul_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == DECODE) cond_ex_q <= cond_ok;
      if (state == EXECMUL) mul_cnt <= mul_done ? '0 : mul_cnt + CNT_W'(1);
      if (exec_last && s_bit && cond_ex_q) begin
        flags[3:2] <= ALUFlags[3:2];
        if (cv_upd) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Next-state and per-state control outputs
  always_comb begin
    state_nx   = FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALUCTRL_W'(ALU_ADD);
    Illegal    = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_nx  = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b01:   state_nx = MEMADR;
          2'b10:   state_nx = BRANCH;
          2'b00:   state_nx = is_mul ? EXECMUL : (Instr[25] ? EXECUTEI : EXECUTER);
          default: begin state_nx = FETCH; Illegal = 1'b1; end
        endcase
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        ALUControl = ALUCTRL_W'(Instr[23] ? ALU_ADD : ALU_SUB);
        state_nx   = Instr[20] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc   = 1'b1;
        state_nx = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex_q;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex_q;
      end
      EXECUTER: begin
        ALUControl = ALUCTRL_W'(dp_op);
        state_nx   = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = ALUCTRL_W'(dp_op);
        state_nx   = ALUWB;
      end
      EXECMUL: begin
        ALUControl = ALUCTRL_W'(ALU_MUL);
        state_nx   = mul_done ? ALUWB : EXECMUL;
      end
      ALUWB: begin
        RegWrite = cond_ex_q & ~nowrite;
        PCWrite  = cond_ex_q & ~nowrite & (Instr[15:12] == 4'hF);
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex_q;
      end
      default: state_nx = FETCH;
    endcase
    // An asserted reset aborts any write in flight
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

endmodule
